// File: rtl/dice_pkg.sv
// Shared constants and roller state encoding for the dice roller and its debouncer.
package dice_pkg;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;
  localparam logic [3:0] SUM_MIN = 4'd2;
  localparam logic [3:0] SUM_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } roll_state_t;

  function automatic logic die_ok(input logic [2:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_roller_btn_debounce.sv
// Roll-button synchronizer and press/release debouncer.
// state       | meaning
// IDLE        | button released, rb low
// PRESS_DEB   | counting consecutive synced highs, rb low
// HELD        | press accepted, rb high
// RELEASE_DEB | counting consecutive synced lows, rb high
module btn_debounce
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rb,
  output logic roll_done,
  output logic accept
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic              sync1;
  logic              btn_s;
  logic [1:0]        fill;
  logic              armed;
  roll_state_t       state;
  logic [CNT_W-1:0]  count;

  // A button held through reset must be seen low before it may roll; the
  // synchronizer's reset zeros do not count until it has refilled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && !btn_s) armed <= 1'b1;
    end
  end

  assign accept = (state == PRESS_DEB) && btn_s && (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      rb        <= 1'b0;
      roll_done <= 1'b0;
    end else begin
      roll_done <= 1'b0;
      case (state)
        IDLE: begin
          rb <= 1'b0;
          if (btn_s && armed) begin
            state <= PRESS_DEB;
            count <= CNT_ONE;
          end
        end
        PRESS_DEB: begin
          if (!btn_s) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state     <= HELD;
            count     <= '0;
            rb        <= 1'b1;
            roll_done <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_DEB;
            count <= CNT_ONE;
          end
        end
        RELEASE_DEB: begin
          if (btn_s) begin
            state <= HELD;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state <= IDLE;
            count <= '0;
            rb    <= 1'b0;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          rb    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Free-running two-dice counter; latches die values and sum when a debounced press is accepted.
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       rb,
  output logic [3:0] sum,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic       roll_done
);

  logic       accept;
  logic [2:0] fr1;
  logic [2:0] fr2;
  logic [2:0] fr1_next;
  logic [2:0] fr2_next;
  logic       fr1_wrap;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .rb        (rb),
    .roll_done (roll_done),
    .accept    (accept)
  );

  // An out-of-range die (upset) is forced back to 1 and does not count as a wrap.
  always_comb begin
    fr1_wrap = die_ok(fr1) && (fr1 == DIE_MAX);
    fr1_next = (!die_ok(fr1) || fr1_wrap) ? DIE_MIN : fr1 + 3'd1;
    fr2_next = fr2;
    if (!die_ok(fr2))
      fr2_next = DIE_MIN;
    else if (fr1_wrap)
      fr2_next = (fr2 == DIE_MAX) ? DIE_MIN : fr2 + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fr1 <= DIE_MIN;
      fr2 <= DIE_MIN;
    end else begin
      fr1 <= fr1_next;
      fr2 <= fr2_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      die1 <= DIE_MIN;
      die2 <= DIE_MIN;
      sum  <= SUM_MIN;
    end else if (accept) begin
      die1 <= fr1;
      die2 <= fr2;
      sum  <= {1'b0, fr1} + {1'b0, fr2};
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with a short debounce window and a cycle-level dice model.
module tb_dice_roller;
  import dice_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_raw = 1'b0;
  logic       rb;
  logic [3:0] sum;
  logic [2:0] die1;
  logic [2:0] die2;
  logic       roll_done;

  int total = 0;
  int bad = 0;
  int rolls = 0;
  logic [2:0] m1 = 3'd1, m2 = 3'd1, p1 = 3'd1, p2 = 3'd1;
  int e1, e2, es;
  bit seen_pair [6][6];
  bit seen_sum [13];

  dice_roller #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .rb        (rb),
    .sum       (sum),
    .die1      (die1),
    .die2      (die2),
    .roll_done (roll_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock; p1/p2 hold the model dice as seen just before the edge.
  task automatic tick();
    p1 = m1;
    p2 = m2;
    @(posedge clk);
    if (rst) begin
      if (m1 == 3'd6) begin
        m1 = 3'd1;
        m2 = (m2 == 3'd6) ? 3'd1 : m2 + 3'd1;
      end else begin
        m1 = m1 + 3'd1;
      end
    end
    #1;
    if (roll_done === 1'b1) rolls++;
  endtask

  task automatic check_roll(input string tag);
    e1 = int'(p1);
    e2 = int'(p2);
    es = e1 + e2;
    check({tag, "_done"}, roll_done, 1);
    check({tag, "_die1"}, die1, e1);
    check({tag, "_die2"}, die2, e2);
    check({tag, "_sum"}, sum, es);
  endtask

  initial begin
    bit b3 [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    bit b4 [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int r0;
    bit got;

    // reset state
    tick();
    tick();
    check("rst_rb", rb, 0);
    check("rst_done", roll_done, 0);
    check("rst_die1", die1, 1);
    check("rst_die2", die2, 1);
    check("rst_sum", sum, 2);
    rst = 1'b1;
    repeat (5) tick();

    // clean press: rb rises 2+DEB clocks after the edge
    btn_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("t2_rb_early", rb, 0);
    end
    check("t2_rb", rb, 1);
    check_roll("t2");
    check("t2_range", (sum >= SUM_MIN) && (sum <= SUM_MAX), 1);
    tick();
    check("t2_done_pulse", roll_done, 0);
    repeat (3) tick();
    check("t2_rolls", rolls, 1);

    btn_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("t2_rel_rb_early", rb, 1);
    end
    check("t2_rel_rb", rb, 0);
    check("t2_idle_sum", sum, es);
    check("t2_idle_die1", die1, e1);
    repeat (3) tick();

    // press bounce: rb rises at step 9
    for (int i = 0; i < 12; i++) begin
      btn_raw = b3[i];
      tick();
      check("t3_rb", rb, (i + 1 >= 9) ? 1 : 0);
      if (i + 1 == 9) check_roll("t3");
      else check("t3_done", roll_done, 0);
    end
    check("t3_rolls", rolls, 2);

    // release bounce: rb falls at step 9, nothing relatched
    for (int i = 0; i < 12; i++) begin
      btn_raw = b4[i];
      tick();
      check("t4_rb", rb, (i + 1 < 9) ? 1 : 0);
      check("t4_done", roll_done, 0);
    end
    check("t4_rolls", rolls, 2);
    check("t4_sum", sum, es);
    check("t4_die1", die1, e1);
    check("t4_die2", die2, e2);

    // coverage over many presses at random gaps
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 40)) tick();
      btn_raw = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (roll_done === 1'b1) begin
          check_roll("t5");
          if (die1 >= 3'd1 && die1 <= 3'd6 && die2 >= 3'd1 && die2 <= 3'd6)
            seen_pair[int'(die1) - 1][int'(die2) - 1] = 1'b1;
          if (sum <= 4'd12) seen_sum[sum] = 1'b1;
          got = 1'b1;
          break;
        end
      end
      if (!got) check("t5_press_timeout", 0, 1);
      repeat ($urandom_range(0, 3)) tick();
      btn_raw = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (rb === 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) check("t5_release_timeout", 0, 1);
    end
    for (int a = 0; a < 6; a++)
      for (int b = 0; b < 6; b++)
        check($sformatf("t5_pair_%0d_%0d", a + 1, b + 1), seen_pair[a][b], 1);
    for (int s = 2; s <= 12; s++)
      check($sformatf("t5_sum_%0d", s), seen_sum[s], 1);

    // reset mid-cycle while held
    repeat (3) tick();
    btn_raw = 1'b1;
    repeat (8) tick();
    check("t6_held", rb, 1);
    #2;
    rst = 1'b0;
    m1 = 3'd1;
    m2 = 3'd1;
    #1;
    check("t6_rst_rb", rb, 0);
    check("t6_rst_done", roll_done, 0);
    check("t6_rst_die1", die1, 1);
    check("t6_rst_die2", die2, 1);
    check("t6_rst_sum", sum, 2);
    tick();
    rst = 1'b1;
    r0 = rolls;
    repeat (20) tick();
    check("t6_no_roll_rb", rb, 0);
    check("t6_no_roll_cnt", rolls, r0);
    btn_raw = 1'b0;
    repeat (8) tick();
    btn_raw = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (roll_done === 1'b1) begin
        check_roll("t6");
        got = 1'b1;
        break;
      end
    end
    if (!got) check("t6_press_timeout", 0, 1);
    repeat (10) tick();
    check("t6_one_roll", rolls, r0 + 1);
    check("t6_rb_held", rb, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
